// File: rtl/vend_change.sv
// rtl/vend_change.sv - coin-operated vending controller with greedy change return
//
// Purpose: accumulates 10/50/100 yen coins into a credit register, dispenses
// one product when credit reaches PRICE, then returns any remainder one coin
// per clock (largest denomination first). Cancel in COLLECT refunds the credit.
//
// Parameters:
//   PRICE  product price in yen (multiple of 10, >= 10)
//   CW     credit register width (2**CW > PRICE + 100)
// Ports:
//   ck               clock, rising edge active
//   res              asynchronous active-low reset
//   c10, c50, c100   one-clock coin-inserted pulses
//   cancel           one-clock refund request
//   credit           registered current credit in yen
//   z                dispense pulse (one clock per product)
//   r10, r50, r100   return-coin pulses, at most one per clock
//   rej              registered pulse when an inserted coin is not credited
//   busy             high in VEND or CHANGE; coins are rejected meanwhile

module vend_change #(
  parameter int PRICE = 300,
  parameter int CW    = 10
) (
  input  logic          ck,
  input  logic          res,
  input  logic          c10,
  input  logic          c50,
  input  logic          c100,
  input  logic          cancel,
  output logic [CW-1:0] credit,
  output logic          z,
  output logic          r10,
  output logic          r50,
  output logic          r100,
  output logic          rej,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] PRICE_V = CW'(PRICE);
  localparam logic [CW-1:0] V10     = CW'(10);
  localparam logic [CW-1:0] V50     = CW'(50);
  localparam logic [CW-1:0] V100    = CW'(100);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_d;
  logic          rej_d;

  logic [1:0]    coin_cnt;
  logic          any_coin;
  logic          multi_coin;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum;
  logic [CW-1:0] vend_rem;
  logic [CW-1:0] ret_val;
  logic [CW-1:0] change_rem;

  // Coin decode; coin_val is only meaningful when exactly one coin is high.
  always_comb begin
    coin_cnt   = 2'(c10) + 2'(c50) + 2'(c100);
    any_coin   = (coin_cnt != 2'd0);
    multi_coin = (coin_cnt >= 2'd2);
    coin_val   = '0;
    if (c10)       coin_val = V10;
    else if (c50)  coin_val = V50;
    else if (c100) coin_val = V100;
  end

  // Moore outputs decoded from registered state and credit only.
  always_comb begin
    z    = (state_q == VEND);
    busy = (state_q == VEND) || (state_q == CHANGE);
    r100 = (state_q == CHANGE) && (credit >= V100);
    r50  = (state_q == CHANGE) && (credit < V100) && (credit >= V50);
    r10  = (state_q == CHANGE) && (credit < V50);
  end

  always_comb begin
    ret_val = '0;
    if (r100)      ret_val = V100;
    else if (r50)  ret_val = V50;
    else if (r10)  ret_val = V10;
  end

  // Max credit before a coin is PRICE-10, so sum never exceeds PRICE+90.
  assign sum        = credit + coin_val;
  assign vend_rem   = credit - PRICE_V;
  assign change_rem = credit - ret_val;

  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    rej_d    = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          // Cancel wins over any coin on the same edge; IDLE has nothing to refund.
          rej_d = any_coin;
          if (state_q == COLLECT) state_d = CHANGE;
        end else if (multi_coin) begin
          rej_d = 1'b1;
        end else if (any_coin) begin
          credit_d = sum;
          state_d  = (sum >= PRICE_V) ? VEND : COLLECT;
        end
      end
      VEND: begin
        rej_d    = any_coin;
        credit_d = vend_rem;
        state_d  = (vend_rem != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d    = any_coin;
        credit_d = change_rem;
        if (change_rem == '0) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      credit  <= '0;
      rej     <= 1'b0;
    end else begin
      state_q <= state_d;
      credit  <= credit_d;
      rej     <= rej_d;
    end
  end

endmodule

// File: tb/tb_vend_change.sv
// tb/tb_vend_change.sv - self-checking bench for vend_change (PRICE = 300)

module tb_vend_change;

  localparam int PRICE = 300;
  localparam int CW    = 10;

  logic          ck;
  logic          res;
  logic          c10, c50, c100, cancel;
  logic [CW-1:0] credit;
  logic          z, r10, r50, r100, rej, busy;

  vend_change #(.PRICE(PRICE), .CW(CW)) dut (
    .ck     (ck),
    .res    (res),
    .c10    (c10),
    .c50    (c50),
    .c100   (c100),
    .cancel (cancel),
    .credit (credit),
    .z      (z),
    .r10    (r10),
    .r50    (r50),
    .r100   (r100),
    .rej    (rej),
    .busy   (busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic c10, c50, c100, cancel;
    int   credit;
    logic z, r10, r50, r100, rej, busy;
  } vec_t;

  typedef struct {
    int   credit;
    logic z, r10, r50, r100, rej, busy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic i10, input logic i50, input logic i100,
                              input logic icn, input int ecr, input logic ez,
                              input logic e10, input logic e50, input logic e100,
                              input logic erj, input logic eb);
    vec_t v;
    v.c10 = i10; v.c50 = i50; v.c100 = i100; v.cancel = icn;
    v.credit = ecr; v.z = ez; v.r10 = e10; v.r50 = e50; v.r100 = e100;
    v.rej = erj; v.busy = eb;
    return v;
  endfunction

  task automatic check_outputs(input string name, input exp_t e);
    n_tests++;
    if (int'(credit) !== e.credit || z !== e.z || r10 !== e.r10 || r50 !== e.r50 ||
        r100 !== e.r100 || rej !== e.rej || busy !== e.busy) begin
      n_fail++;
      $display("FAIL %s: got credit=%0d z=%b r10=%b r50=%b r100=%b rej=%b busy=%b, want credit=%0d z=%b r10=%b r50=%b r100=%b rej=%b busy=%b",
               name, credit, z, r10, r50, r100, rej, busy,
               e.credit, e.z, e.r10, e.r50, e.r100, e.rej, e.busy);
    end
  endtask

  // Drive one edge of stimulus, queue its expectation, then compare after the edge.
  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    @(negedge ck);
    c10 = v.c10; c50 = v.c50; c100 = v.c100; cancel = v.cancel;
    e.credit = v.credit; e.z = v.z; e.r10 = v.r10; e.r50 = v.r50;
    e.r100 = v.r100; e.rej = v.rej; e.busy = v.busy;
    exp_q.push_back(e);
    @(posedge ck);
    #1;
    check_outputs(name, exp_q.pop_front());
  endtask

  function automatic exp_t all_zero();
    exp_t e;
    e.credit = 0; e.z = 0; e.r10 = 0; e.r50 = 0; e.r100 = 0; e.rej = 0; e.busy = 0;
    return e;
  endfunction

  initial begin
    //              c10 c50 c100 cn  credit z r10 r50 r100 rej busy
    // three c100 -> exact price, no change
    vecs.push_back(mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 200, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 300, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // 350 -> vend then r50
    vecs.push_back(mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 200, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 250, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 350, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  50, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // c50, c10, cancel -> r50, r10
    vecs.push_back(mk(0, 1, 0, 0,  50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  60, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  60, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  10, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // double coin rejected; coin during VEND rejected
    vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 200, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 300, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // cancel in IDLE ignored; cancel + coin in COLLECT
    vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1,  50, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // cancel at 150 -> r100, coin during CHANGE rejected, r50
    vecs.push_back(mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 150, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 150, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  50, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // three coins at once in IDLE
    vecs.push_back(mk(1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // credit 390 (PRICE+90) -> z, r50, r10 x4
    vecs.push_back(mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 200, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 250, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 260, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 270, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 280, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 290, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 390, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  90, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  40, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  30, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  20, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  10, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));

    c10 = 0; c50 = 0; c100 = 0; cancel = 0;
    res = 0;
    #2;
    check_outputs("reset_state", all_zero());
    @(posedge ck);
    #1;
    check_outputs("reset_held", all_zero());
    @(negedge ck);
    res = 1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Async reset in the cycle of the first r10 of a 390 vend.
    for (int i = 32; i <= 41; i++) run_vec($sformatf("rst_seq%0d", i), vecs[i]);
    #2;
    res = 0;
    #1;
    check_outputs("async_reset", all_zero());
    @(posedge ck);
    #1;
    check_outputs("reset_no_return", all_zero());
    @(negedge ck);
    res = 1;
    for (int i = 0; i < 3; i++)
      run_vec($sformatf("post_reset_idle%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec("first_edge_after_reset", mk(0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0));
    run_vec("post_reset_cancel",      mk(0, 0, 0, 1, 100, 0, 0, 0, 1, 0, 1));
    run_vec("post_reset_done",        mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
